// File: rtl/axis_stacker_param.sv
// axis_stacker_param: AXI-Stream width up-converter.
// Packs IN_W-bit pixel beats into OUT_W-bit chunks (RATIO lanes). A beat with
// pixel_tlast closes the chunk early; unfilled lanes carry PAD and are cleared
// in chunk_tkeep. The chunk_* outputs are registered. A new chunk can load in
// the same cycle the previous one drains, so input runs at full rate while
// chunk_tready stays high.
`timescale 1ns/1ps

module axis_stacker_param #(
  parameter int              IN_W      = 8,
  parameter int              OUT_W     = 128,
  parameter bit              LSB_FIRST = 1'b1,
  parameter logic [IN_W-1:0] PAD       = '0
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     pixel_tvalid,
  output logic                     pixel_tready,
  input  logic [IN_W-1:0]          pixel_tdata,
  input  logic                     pixel_tlast,
  output logic                     chunk_tvalid,
  input  logic                     chunk_tready,
  output logic [OUT_W-1:0]         chunk_tdata,
  output logic [(OUT_W/IN_W)-1:0]  chunk_tkeep,
  output logic                     chunk_tlast
);

  localparam int RATIO = OUT_W / IN_W;
  localparam int LW    = (RATIO > 1) ? $clog2(RATIO) : 1;

  if ((OUT_W % IN_W) != 0) begin : g_bad_ratio
    $error("axis_stacker_param: OUT_W must be a multiple of IN_W");
  end

  logic [LW-1:0]    lane;
  logic [OUT_W-1:0] acc;
  logic [RATIO-1:0] keep_acc;

  logic             completing;
  logic             accept_in;
  logic             accept_out;
  logic             load;
  logic [OUT_W-1:0] acc_wr;
  logic [OUT_W-1:0] chunk_nx;
  logic [RATIO-1:0] keep_wr;

  // Bit offset of lane i; lane 0 sits at the bottom or the top of the chunk.
  function automatic int lane_lo(input int i);
    if (LSB_FIRST) return i * IN_W;
    else           return OUT_W - (i + 1) * IN_W;
  endfunction

  // A completing beat only stalls when the output register is still occupied.
  assign completing   = (lane == LW'(RATIO - 1)) | pixel_tlast;
  assign pixel_tready = ~completing | ~chunk_tvalid | chunk_tready;
  assign accept_in    = pixel_tvalid & pixel_tready;
  assign accept_out   = chunk_tvalid & chunk_tready;
  assign load         = accept_in & completing;
  assign keep_wr      = keep_acc | (RATIO'(1) << lane);

  // Merge the incoming beat into the accumulator; lanes above it get PAD for a closing chunk.
  always_comb begin
    acc_wr   = acc;
    chunk_nx = acc;
    for (int i = 0; i < RATIO; i++) begin
      if (i == int'(lane)) begin
        acc_wr[lane_lo(i) +: IN_W]   = pixel_tdata;
        chunk_nx[lane_lo(i) +: IN_W] = pixel_tdata;
      end else if (i > int'(lane)) begin
        chunk_nx[lane_lo(i) +: IN_W] = PAD;
      end
    end
  end

  // Lane accumulation and the registered output stage; a load overrides a drain.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      lane         <= '0;
      acc          <= '0;
      keep_acc     <= '0;
      chunk_tvalid <= 1'b0;
      chunk_tdata  <= '0;
      chunk_tkeep  <= '0;
      chunk_tlast  <= 1'b0;
    end else begin
      if (accept_out) begin
        chunk_tvalid <= 1'b0;
      end
      if (accept_in) begin
        if (load) begin
          chunk_tvalid <= 1'b1;
          chunk_tdata  <= chunk_nx;
          chunk_tkeep  <= keep_wr;
          chunk_tlast  <= pixel_tlast;
          lane         <= '0;
          keep_acc     <= '0;
          acc          <= {RATIO{PAD}};
        end else begin
          acc      <= acc_wr;
          keep_acc <= keep_wr;
          lane     <= lane + LW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_axis_stacker_param.sv
// Testbench for axis_stacker_param: randomized beats, a packet-level reference
// model feeding an expected-chunk queue, and an independent output monitor.
`timescale 1ns/1ps

module tb_axis_stacker_param;

  localparam int OUT_W = 128;
  localparam int RATIO = 16;

  typedef struct {
    logic [OUT_W-1:0] d;
    logic [RATIO-1:0] k;
    logic             l;
  } chunk_t;

  logic clk_in = 1'b0;
  logic rst_in;
  always #5 clk_in = ~clk_in;

  logic             pixel_tvalid, pixel_tready, pixel_tlast;
  logic [7:0]       pixel_tdata;
  logic             chunk_tvalid, chunk_tready, chunk_tlast;
  logic [OUT_W-1:0] chunk_tdata;
  logic [RATIO-1:0] chunk_tkeep;

  logic             p2_tvalid, p2_tready, p2_tlast;
  logic [7:0]       p2_tdata;
  logic             c2_tvalid, c2_tready, c2_tlast;
  logic [OUT_W-1:0] c2_tdata;
  logic [RATIO-1:0] c2_tkeep;

  axis_stacker_param #(.IN_W(8), .OUT_W(128), .LSB_FIRST(1'b1), .PAD(8'h00)) dut (
    .clk_in(clk_in), .rst_in(rst_in),
    .pixel_tvalid(pixel_tvalid), .pixel_tready(pixel_tready),
    .pixel_tdata(pixel_tdata), .pixel_tlast(pixel_tlast),
    .chunk_tvalid(chunk_tvalid), .chunk_tready(chunk_tready),
    .chunk_tdata(chunk_tdata), .chunk_tkeep(chunk_tkeep), .chunk_tlast(chunk_tlast));

  axis_stacker_param #(.IN_W(8), .OUT_W(128), .LSB_FIRST(1'b0), .PAD(8'hFF)) dut_msb (
    .clk_in(clk_in), .rst_in(rst_in),
    .pixel_tvalid(p2_tvalid), .pixel_tready(p2_tready),
    .pixel_tdata(p2_tdata), .pixel_tlast(p2_tlast),
    .chunk_tvalid(c2_tvalid), .chunk_tready(c2_tready),
    .chunk_tdata(c2_tdata), .chunk_tkeep(c2_tkeep), .chunk_tlast(c2_tlast));

  int n_vec = 0;
  int n_bad = 0;
  int ready_pct = 100;
  chunk_t     exp_q[$];
  logic [7:0] cur[$];
  logic             held = 1'b0;
  logic [OUT_W-1:0] held_d;
  logic [RATIO-1:0] held_k;
  logic             held_l;

  task automatic chk(input string nm, input logic [OUT_W-1:0] got, input logic [OUT_W-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // Reference: a chunk is just the packet's bytes in order, PAD beyond, keep = filled lanes.
  function automatic chunk_t build_chunk(input logic [7:0] b[$], input bit last,
                                         input bit lsb, input logic [7:0] pad);
    chunk_t c;
    c.d = '0;
    c.k = '0;
    c.l = last;
    for (int i = 0; i < RATIO; i++) begin
      logic [7:0] v;
      v = (i < b.size()) ? b[i] : pad;
      if (i < b.size()) c.k[i] = 1'b1;
      if (lsb) c.d[i*8 +: 8] = v;
      else     c.d[OUT_W-8-i*8 +: 8] = v;
    end
    return c;
  endfunction

  task automatic model_accept(input logic [7:0] d, input bit last);
    cur.push_back(d);
    if (cur.size() == RATIO || last) begin
      exp_q.push_back(build_chunk(cur, last, 1'b1, 8'h00));
      cur.delete();
    end
  endtask

  // Downstream ready pattern.
  initial begin
    chunk_tready = 1'b1;
    forever begin
      @(negedge clk_in);
      chunk_tready = ($urandom_range(0, 99) < ready_pct);
    end
  end

  // Monitor: pops on every output handshake, checks stability during stalls.
  initial begin
    forever begin
      @(negedge clk_in);
      #2;
      if (rst_in) begin
        held = 1'b0;
      end else begin
        if (held) begin
          chk("hold_valid", 128'(chunk_tvalid), 128'(1));
          chk("hold_data", chunk_tdata, held_d);
          chk("hold_keep", 128'(chunk_tkeep), 128'(held_k));
          chk("hold_last", 128'(chunk_tlast), 128'(held_l));
        end
        if (chunk_tvalid && chunk_tready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_chunk", 128'(exp_q.size()), 128'(1));
          end else begin
            chunk_t e;
            e = exp_q.pop_front();
            chk("chunk_data", chunk_tdata, e.d);
            chk("chunk_keep", 128'(chunk_tkeep), 128'(e.k));
            chk("chunk_last", 128'(chunk_tlast), 128'(e.l));
          end
        end
        held   = chunk_tvalid && !chunk_tready;
        held_d = chunk_tdata;
        held_k = chunk_tkeep;
        held_l = chunk_tlast;
      end
    end
  end

  task automatic send_beat(input logic [7:0] d, input bit last, output int stalls);
    stalls = 0;
    @(negedge clk_in);
    pixel_tvalid = 1'b1;
    pixel_tdata  = d;
    pixel_tlast  = last;
    #2;
    while (!pixel_tready) begin
      chk("ready_low_cause",
          128'(((cur.size() == RATIO - 1) || last) && !chunk_tready), 128'(1));
      stalls++;
      if (stalls > 500) begin
        chk("input_stall_timeout", 128'(stalls), 128'(0));
        return;
      end
      @(negedge clk_in);
      #2;
    end
    model_accept(d, last);
    @(posedge clk_in);
  endtask

  task automatic stop_in();
    @(negedge clk_in);
    pixel_tvalid = 1'b0;
    pixel_tlast  = 1'b0;
  endtask

  task automatic drain();
    int n;
    ready_pct = 100;
    stop_in();
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk_in);
      n++;
    end
    chk("drain_queue_empty", 128'(exp_q.size()), 128'(0));
    @(negedge clk_in);
    #3;
    chk("drain_valid_low", 128'(chunk_tvalid), 128'(0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int st, tot;
    logic [7:0] b;
    bit last;
    rst_in = 1'b1;
    pixel_tvalid = 1'b0; pixel_tdata = '0; pixel_tlast = 1'b0;
    p2_tvalid = 1'b0; p2_tdata = '0; p2_tlast = 1'b0; c2_tready = 1'b1;
    #1;
    chk("reset_valid", 128'(chunk_tvalid), 128'(0));
    chk("reset_data", chunk_tdata, 128'(0));
    chk("reset_keep", 128'(chunk_tkeep), 128'(0));
    chk("reset_last", 128'(chunk_tlast), 128'(0));
    chk("reset_tready", 128'(pixel_tready), 128'(1));
    repeat (3) @(negedge clk_in);
    rst_in = 1'b0;

    // T1: one full chunk, no stalls, chunk one cycle after the last byte.
    tot = 0;
    for (int i = 0; i < 16; i++) begin
      send_beat(8'(i), 1'b0, st);
      tot += st;
    end
    @(negedge clk_in);
    pixel_tvalid = 1'b0;
    #2;
    chk("t1_latency_valid", 128'(chunk_tvalid), 128'(1));
    chk("t1_data", chunk_tdata, 128'h0F0E0D0C0B0A09080706050403020100);
    chk("t1_keep", 128'(chunk_tkeep), 128'(16'hFFFF));
    chk("t1_stalls", 128'(tot), 128'(0));

    // T2: short packet closed by tlast.
    for (int i = 0; i < 5; i++) send_beat(8'(8'hA0 + i), (i == 4), st);
    @(negedge clk_in);
    pixel_tvalid = 1'b0;
    pixel_tlast  = 1'b0;
    #2;
    chk("t2_data", chunk_tdata, 128'h000000000000000000000000A4A3A2A1A0);
    chk("t2_keep", 128'(chunk_tkeep), 128'(16'h001F));
    chk("t2_last", 128'(chunk_tlast), 128'(1));
    drain();

    // T4: continuous stream, downstream always ready.
    tot = 0;
    for (int i = 0; i < 64; i++) begin
      send_beat(8'($urandom), 1'b0, st);
      tot += st;
    end
    chk("t4_stalls", 128'(tot), 128'(0));
    drain();

    // T3: 48 bytes against a 30% ready downstream.
    ready_pct = 30;
    for (int i = 0; i < 48; i++) send_beat(8'($urandom), 1'b0, st);
    drain();

    // Random packets with random tlast, input gaps and backpressure.
    ready_pct = 50;
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 3) == 0) stop_in();
      b    = 8'($urandom);
      last = ($urandom_range(0, 9) == 0) || (i == 199);
      send_beat(b, last, st);
    end
    drain();

    // T5: reset mid-cycle with a held chunk and 7 partial bytes.
    ready_pct = 0;
    for (int i = 0; i < 23; i++) send_beat(8'($urandom), 1'b0, st);
    stop_in();
    @(posedge clk_in);
    #3;
    rst_in = 1'b1;
    exp_q.delete();
    cur.delete();
    held = 1'b0;
    #1;
    chk("t5_rst_valid", 128'(chunk_tvalid), 128'(0));
    chk("t5_rst_data", chunk_tdata, 128'(0));
    chk("t5_rst_keep", 128'(chunk_tkeep), 128'(0));
    chk("t5_rst_last", 128'(chunk_tlast), 128'(0));
    @(negedge clk_in);
    @(negedge clk_in);
    rst_in = 1'b0;
    ready_pct = 100;
    for (int i = 0; i < 16; i++) send_beat(8'($urandom), 1'b0, st);
    drain();

    // T6: MSB-first lane order with 0xFF padding.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_in);
      p2_tvalid = 1'b1;
      p2_tdata  = 8'(8'h11 * (i + 1));
      p2_tlast  = (i == 2);
      #2;
      chk("t6_tready", 128'(p2_tready), 128'(1));
      @(posedge clk_in);
    end
    @(negedge clk_in);
    p2_tvalid = 1'b0;
    p2_tlast  = 1'b0;
    #2;
    chk("t6_valid", 128'(c2_tvalid), 128'(1));
    chk("t6_data", c2_tdata, {8'h11, 8'h22, 8'h33, {13{8'hFF}}});
    chk("t6_keep", 128'(c2_tkeep), 128'(16'h0007));
    chk("t6_last", 128'(c2_tlast), 128'(1));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
